// File: rtl/exc_req_ctrl_if.sv
// -----------------------------------------------------------------------------
// exc_req_ctrl_if
//   Signal bundle between the decode/execute stage, the PC register, CP0 and
//   the exception request controller.
//
//   master modport: the controller side (exc_req_ctrl).
//     inputs : syscall_i, break_i, teq_i, teq_eq_i, eret_i, pc_i, status_i,
//              epc_i
//     outputs: stall_o, exc_commit_o, eret_commit_o, cause_o, epc_o,
//              redirect_o, redirect_addr_o, busy_o
//              exc_cnt_o (only when EXC_CNT_EN is defined)
//   slave modport: the surrounding pipeline/CP0 side (directions mirrored).
//
//   Optional feature macro: EXC_CNT_EN (adds the exc_cnt_o counter output).
// -----------------------------------------------------------------------------
interface exc_req_ctrl_if;
  logic        syscall_i;
  logic        break_i;
  logic        teq_i;
  logic        teq_eq_i;
  logic        eret_i;
  logic [31:0] pc_i;
  logic [31:0] status_i;
  logic [31:0] epc_i;
  logic        stall_o;
  logic        exc_commit_o;
  logic        eret_commit_o;
  logic [3:0]  cause_o;
  logic [31:0] epc_o;
  logic        redirect_o;
  logic [31:0] redirect_addr_o;
  logic        busy_o;
`ifdef EXC_CNT_EN
  logic [31:0] exc_cnt_o;
`endif

  modport master (
`ifdef EXC_CNT_EN
    output exc_cnt_o,
`endif
    input  syscall_i, break_i, teq_i, teq_eq_i, eret_i,
    input  pc_i, status_i, epc_i,
    output stall_o, exc_commit_o, eret_commit_o, cause_o, epc_o,
    output redirect_o, redirect_addr_o, busy_o
  );

  modport slave (
`ifdef EXC_CNT_EN
    input  exc_cnt_o,
`endif
    output syscall_i, break_i, teq_i, teq_eq_i, eret_i,
    output pc_i, status_i, epc_i,
    input  stall_o, exc_commit_o, eret_commit_o, cause_o, epc_o,
    input  redirect_o, redirect_addr_o, busy_o
  );
endinterface

// File: rtl/exc_req_ctrl.sv
// -----------------------------------------------------------------------------
// exc_req_ctrl
//   Initiator side of the CP0 exception interface. Qualifies decoded trap
//   instructions (syscall, break, teq) and eret against the CP0 status mask,
//   then sequences a three-cycle trap entry or trap return:
//     entry : detect (stall) -> EXC_SAVE (exc_commit) -> EXC_JUMP (redirect
//             to EXC_VECTOR)
//     return: detect (stall) -> RET_POP (eret_commit) -> RET_JUMP (redirect
//             to the EPC latched at detect time)
//
//   Ports:
//     clk   - system clock, rising edge
//     rst_n - asynchronous active-low reset
//     bus   - exc_req_ctrl_if.master carrying the decode inputs, CP0 status
//             and EPC, and all stall/strobe/redirect outputs
//
//   Optional feature macro: EXC_CNT_EN
//     When defined, bus.exc_cnt_o counts exc_commit_o cycles (wraps at 2^32).
// -----------------------------------------------------------------------------
module exc_req_ctrl #(
  parameter logic [31:0] EXC_VECTOR    = 32'h0040_0004,
  parameter logic [3:0]  CAUSE_SYSCALL = 4'd8,
  parameter logic [3:0]  CAUSE_BREAK   = 4'd9,
  parameter logic [3:0]  CAUSE_TEQ     = 4'd13
) (
  input logic              clk,
  input logic              rst_n,
  exc_req_ctrl_if.master   bus
);

  typedef enum logic [2:0] {
    IDLE,
    EXC_SAVE,
    EXC_JUMP,
    RET_POP,
    RET_JUMP
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cause_q, cause_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] ret_q, ret_d;

  logic        brk_hit, sys_hit, teq_hit, trap_hit;

  logic        stall;
  logic        exc_commit;
  logic        eret_commit;
  logic        redirect;
  logic [31:0] redirect_addr;

  // Only the enable bits [3:0] of status are meaningful here.
  logic unused_status;
  assign unused_status = ^bus.status_i[31:4];

  // Trap qualification against the status mask of the current cycle; only
  // consulted while IDLE, so CP0 rewriting status mid-sequence is harmless.
  assign brk_hit  = bus.status_i[0] & bus.status_i[2] & bus.break_i;
  assign sys_hit  = bus.status_i[0] & bus.status_i[1] & bus.syscall_i;
  assign teq_hit  = bus.status_i[0] & bus.status_i[3] & bus.teq_i & bus.teq_eq_i;
  assign trap_hit = brk_hit | sys_hit | teq_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cause_q <= 4'd0;
      epc_q   <= 32'd0;
      ret_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      epc_q   <= epc_d;
      ret_q   <= ret_d;
    end
  end

  // Any qualified trap wins over a simultaneous eret, which is dropped.
  // Among traps the order is break, then syscall, then teq.
  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    epc_d   = epc_q;
    ret_d   = ret_q;
    case (state_q)
      IDLE: begin
        if (trap_hit) begin
          state_d = EXC_SAVE;
          epc_d   = bus.pc_i;
          if (brk_hit) begin
            cause_d = CAUSE_BREAK;
          end else if (sys_hit) begin
            cause_d = CAUSE_SYSCALL;
          end else begin
            cause_d = CAUSE_TEQ;
          end
        end else if (bus.eret_i) begin
          state_d = RET_POP;
          ret_d   = bus.epc_i;
        end
      end
      EXC_SAVE: state_d = EXC_JUMP;
      EXC_JUMP: state_d = IDLE;
      RET_POP:  state_d = RET_JUMP;
      RET_JUMP: state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // The detect-cycle stall is combinational so the decode stage holds the
  // trapping instruction in the very cycle it is recognised.
  always_comb begin
    stall         = 1'b0;
    exc_commit    = 1'b0;
    eret_commit   = 1'b0;
    redirect      = 1'b0;
    redirect_addr = 32'd0;
    case (state_q)
      IDLE:     stall = trap_hit | bus.eret_i;
      EXC_SAVE: begin
        stall      = 1'b1;
        exc_commit = 1'b1;
      end
      EXC_JUMP: begin
        redirect      = 1'b1;
        redirect_addr = EXC_VECTOR;
      end
      RET_POP:  begin
        stall       = 1'b1;
        eret_commit = 1'b1;
      end
      RET_JUMP: begin
        redirect      = 1'b1;
        redirect_addr = ret_q;
      end
      default:  stall = 1'b0;
    endcase
  end

  assign bus.stall_o         = stall;
  assign bus.exc_commit_o    = exc_commit;
  assign bus.eret_commit_o   = eret_commit;
  assign bus.redirect_o      = redirect;
  assign bus.redirect_addr_o = redirect_addr;
  assign bus.busy_o          = (state_q != IDLE);
  assign bus.cause_o         = cause_q;
  assign bus.epc_o           = epc_q;

`ifdef EXC_CNT_EN
  logic [31:0] exc_cnt_q, exc_cnt_d;

  always_comb begin
    exc_cnt_d = exc_cnt_q;
    if (exc_commit) begin
      exc_cnt_d = exc_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exc_cnt_q <= 32'd0;
    end else begin
      exc_cnt_q <= exc_cnt_d;
    end
  end

  assign bus.exc_cnt_o = exc_cnt_q;
`endif

endmodule

// File: tb/tb_exc_req_ctrl.sv
// -----------------------------------------------------------------------------
// tb_exc_req_ctrl
//   Scoreboard bench for exc_req_ctrl. The driver applies one input set per
//   cycle and a cycle-level reference model (a countdown of remaining sequence
//   cycles) pushes the expected control outputs and trap/return transactions
//   into queues; an independent monitor pops and compares at the falling edge.
//   Honours EXC_CNT_EN for the optional commit counter.
// -----------------------------------------------------------------------------
module tb_exc_req_ctrl;

  localparam logic [31:0] VEC = 32'h0040_0004;

  typedef struct {
    logic stall;
    logic busy;
    logic exc;
    logic eret;
    logic redir;
  } cyc_t;

  typedef struct {
    logic        is_ret;
    logic [3:0]  cause;
    logic [31:0] epc;
    logic [31:0] addr;
  } txn_t;

  logic clk;
  logic rst_n;

  exc_req_ctrl_if bus();

  exc_req_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  cyc_t  cyc_q[$];
  txn_t  txn_q[$];
  txn_t  pending;
  cyc_t  mon_c;
  logic  mon_en;

  int    model_phase;
  logic  model_is_ret;
  logic [31:0] model_cnt;

  int    tests_run;
  int    tests_failed;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One cycle of stimulus plus the reference model's expectation for it.
  task applyStimulus(input logic sys, input logic brk, input logic teq, input logic eq,
                     input logic eret, input logic [31:0] pc, input logic [31:0] status,
                     input logic [31:0] epc);
    cyc_t c;
    txn_t t;
    logic b_ok, s_ok, t_ok;
    @(posedge clk);
    #1;
    bus.syscall_i = sys;
    bus.break_i   = brk;
    bus.teq_i     = teq;
    bus.teq_eq_i  = eq;
    bus.eret_i    = eret;
    bus.pc_i      = pc;
    bus.status_i  = status;
    bus.epc_i     = epc;
    c.stall = 1'b0; c.busy = 1'b0; c.exc = 1'b0; c.eret = 1'b0; c.redir = 1'b0;
    if (model_phase == 0) begin
      b_ok = status[0] & status[2] & brk;
      s_ok = status[0] & status[1] & sys;
      t_ok = status[0] & status[3] & teq & eq;
      if (b_ok || s_ok || t_ok) begin
        t.is_ret = 1'b0;
        t.cause  = b_ok ? 4'd9 : (s_ok ? 4'd8 : 4'd13);
        t.epc    = pc;
        t.addr   = VEC;
        txn_q.push_back(t);
        c.stall      = 1'b1;
        model_phase  = 2;
        model_is_ret = 1'b0;
      end else if (eret) begin
        t.is_ret = 1'b1;
        t.cause  = 4'd0;
        t.epc    = 32'd0;
        t.addr   = epc;
        txn_q.push_back(t);
        c.stall      = 1'b1;
        model_phase  = 2;
        model_is_ret = 1'b1;
      end
    end else if (model_phase == 2) begin
      c.busy      = 1'b1;
      c.stall     = 1'b1;
      c.exc       = !model_is_ret;
      c.eret      = model_is_ret;
      model_phase = 1;
    end else begin
      c.busy      = 1'b1;
      c.redir     = 1'b1;
      model_phase = 0;
    end
    cyc_q.push_back(c);
  endtask

  task idleCycles(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0040_1000, 32'hF, 32'h0);
    end
  endtask

  // Monitor: pops the per-cycle expectation; commit strobes pop a transaction.
  always @(negedge clk) begin
    if (mon_en && cyc_q.size() > 0) begin
      mon_c = cyc_q.pop_front();
      checkOutput("stall_o",       32'(bus.stall_o),       32'(mon_c.stall));
      checkOutput("busy_o",        32'(bus.busy_o),        32'(mon_c.busy));
      checkOutput("exc_commit_o",  32'(bus.exc_commit_o),  32'(mon_c.exc));
      checkOutput("eret_commit_o", 32'(bus.eret_commit_o), 32'(mon_c.eret));
      checkOutput("redirect_o",    32'(bus.redirect_o),    32'(mon_c.redir));
`ifdef EXC_CNT_EN
      checkOutput("exc_cnt_o", bus.exc_cnt_o, model_cnt);
      if (mon_c.exc) model_cnt = model_cnt + 32'd1;
`endif
      if (bus.exc_commit_o || bus.eret_commit_o) begin
        if (txn_q.size() == 0) begin
          checkOutput("commit_without_event", 32'd1, 32'd0);
        end else begin
          pending = txn_q.pop_front();
          checkOutput("commit_kind", 32'(bus.eret_commit_o), 32'(pending.is_ret));
          if (!pending.is_ret) begin
            checkOutput("cause_o", 32'(bus.cause_o), 32'(pending.cause));
            checkOutput("epc_o",   bus.epc_o,        pending.epc);
          end
        end
      end
      if (bus.redirect_o) begin
        checkOutput("redirect_addr_o", bus.redirect_addr_o, pending.addr);
      end
    end
  end

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    mon_en       = 1'b0;
    model_phase  = 0;
    model_is_ret = 1'b0;
    model_cnt    = 32'd0;
    pending.is_ret = 1'b0; pending.cause = 4'd0; pending.epc = 32'd0; pending.addr = 32'd0;
    bus.syscall_i = 1'b0; bus.break_i = 1'b0; bus.teq_i = 1'b0; bus.teq_eq_i = 1'b0;
    bus.eret_i = 1'b0; bus.pc_i = 32'd0; bus.status_i = 32'd0; bus.epc_i = 32'd0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_stall",    32'(bus.stall_o),      32'd0);
    checkOutput("reset_busy",     32'(bus.busy_o),       32'd0);
    checkOutput("reset_redirect", 32'(bus.redirect_o),   32'd0);
    checkOutput("reset_addr",     bus.redirect_addr_o,   32'd0);
    checkOutput("reset_cause",    32'(bus.cause_o),      32'd0);
    checkOutput("reset_epc",      bus.epc_o,             32'd0);
    checkOutput("reset_exc",      32'(bus.exc_commit_o), 32'd0);
    @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // Enabled syscall, then masked syscall.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0040_0120, 32'h3, 32'h0);
    idleCycles(3);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0040_0124, 32'h1, 32'h0);
    idleCycles(2);
    // teq with unequal operands, then equal.
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0040_0130, 32'h9, 32'h0);
    idleCycles(1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0040_0134, 32'h9, 32'h0);
    idleCycles(3);
    // break and syscall together, then break with eret together.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0040_0140, 32'h7, 32'h0);
    idleCycles(3);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0040_0144, 32'h5, 32'h0040_0999);
    idleCycles(3);
    // eret.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0040_0150, 32'h0, 32'h0040_0200);
    idleCycles(3);
    // Back-to-back: syscall held for several cycles is re-accepted after redirect.
    for (int i = 0; i < 7; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0040_0300 + 32'(i * 4), 32'h3, 32'h0);
    end
    idleCycles(3);

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] st;
      st = {$urandom_range(0, 32'h0FFF_FFFF), 4'($urandom_range(0, 15))};
      if ($urandom_range(0, 3) != 0) st[0] = 1'b1;
      applyStimulus($urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0,
                    $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
                    $urandom_range(0, 4) == 0, $urandom & 32'hFFFF_FFFC, st, $urandom);
    end
    idleCycles(4);
    @(negedge clk);
    #1;
    mon_en = 1'b0;
    checkOutput("txn_queue_drained", 32'(txn_q.size()), 32'd0);

    // Reset in the middle of EXC_SAVE.
    @(posedge clk);
    #1;
    bus.syscall_i = 1'b1; bus.status_i = 32'h3; bus.pc_i = 32'h0040_0500;
    @(posedge clk);
    #1;
    bus.syscall_i = 1'b0;
    checkOutput("pre_reset_exc_commit", 32'(bus.exc_commit_o), 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_stall",    32'(bus.stall_o),      32'd0);
    checkOutput("midrst_exc",      32'(bus.exc_commit_o), 32'd0);
    checkOutput("midrst_busy",     32'(bus.busy_o),       32'd0);
    checkOutput("midrst_redirect", 32'(bus.redirect_o),   32'd0);
    checkOutput("midrst_cause",    32'(bus.cause_o),      32'd0);
    checkOutput("midrst_epc",      bus.epc_o,             32'd0);
    checkOutput("midrst_addr",     bus.redirect_addr_o,   32'd0);
`ifdef EXC_CNT_EN
    checkOutput("midrst_cnt",      bus.exc_cnt_o,         32'd0);
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("postrst_redirect", 32'(bus.redirect_o),    32'd0);
      checkOutput("postrst_exc",      32'(bus.exc_commit_o),  32'd0);
      checkOutput("postrst_eret",     32'(bus.eret_commit_o), 32'd0);
      checkOutput("postrst_busy",     32'(bus.busy_o),        32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/exc_req_ctrl.md
Name: exc_req_ctrl

Overview:
- Initiator side of the CP0 exception interface.
- Watches decoded trap instructions (syscall, break, teq) and eret from the decode/execute stage, and qualifies them against the CP0 status mask.
- Sequences a multi-cycle trap-entry or trap-return: stalls the front end, pulses the CP0 commit strobes, then redirects the PC.
- Sits between the instruction decoder, the PC register and CP0.

Parameters:
- EXC_VECTOR, 32'h0040_0004, PC loaded on trap entry.
- CAUSE_SYSCALL, 4'd8, cause code for syscall.
- CAUSE_BREAK, 4'd9, cause code for break.
- CAUSE_TEQ, 4'd13, cause code for teq trap.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- syscall_i  in  1  current instruction is syscall.
- break_i  in  1  current instruction is break.
- teq_i  in  1  current instruction is teq.
- teq_eq_i  in  1  teq operands equal (rs==rt).
- eret_i  in  1  current instruction is eret.
- pc_i  in  32  PC of current instruction.
- status_i  in  32  CP0 status; bit0 global enable, bit1 syscall, bit2 break, bit3 teq enable.
- epc_i  in  32  CP0 EPC read value.
- stall_o  out  1  hold PC and decode stage.
- exc_commit_o  out  1  one-cycle strobe: CP0 pushes status, writes cause/EPC.
- eret_commit_o  out  1  one-cycle strobe: CP0 pops status.
- cause_o  out  4  cause code presented with exc_commit_o.
- epc_o  out  32  PC presented with exc_commit_o.
- redirect_o  out  1  PC mux select for redirect_addr_o.
- redirect_addr_o  out  32  next-PC target.
- busy_o  out  1  FSM not in IDLE.

Behaviour:
- Reset: rst_n low forces IDLE asynchronously, including mid-sequence.
  - All outputs 0; cause_o=0, epc_o=0, redirect_addr_o=0.
  - Latched cause/EPC/target registers cleared.
  - No strobe is emitted after a reset.
- Qualification, evaluated only in IDLE using status_i of that cycle:
  - brk_q = status[0] & status[2] & break_i
  - sys_q = status[0] & status[1] & syscall_i
  - teq_q = status[0] & status[3] & teq_i & teq_eq_i
- Priority when more than one qualifies: break > syscall > teq.
- Any trap qualifier beats eret_i in the same cycle; the eret is dropped.
- Unqualified trap instructions (masked, or teq with unequal operands) produce no action and behave as NOPs.
- FSM states: IDLE, EXC_SAVE, EXC_JUMP, RET_POP, RET_JUMP.
- Trap entry (event seen in cycle N):
  - Cycle N, IDLE: stall_o=1 combinationally. Latch cause and pc_i at the edge ending N. Next state EXC_SAVE.
  - Cycle N+1, EXC_SAVE: exc_commit_o=1, stall_o=1, cause_o/epc_o show the latched values. Next state EXC_JUMP.
  - Cycle N+2, EXC_JUMP: redirect_o=1, redirect_addr_o=EXC_VECTOR, stall_o=0. PC loads the vector at the end of N+2. Next state IDLE.
- Trap return (eret_i seen in IDLE in cycle N):
  - Cycle N: stall_o=1. Latch epc_i at the edge ending N.
  - Cycle N+1, RET_POP: eret_commit_o=1, stall_o=1.
  - Cycle N+2, RET_JUMP: redirect_o=1, redirect_addr_o=latched EPC (no offset).
- Timing rules:
  - Total latency is 3 cycles from event to redirect.
  - Strobes are exactly one cycle wide.
  - Outside their active state, cause_o/epc_o hold their last values and are don't-care.
  - Inputs are ignored in all non-IDLE states; busy_o=1 there.
- Back-to-back: a new event is accepted in the first IDLE cycle after a JUMP state, at the redirected instruction.
- CP0 changes status during EXC_SAVE/RET_POP. The block never re-reads status_i outside IDLE.

Optional Feature:
- Macro: EXC_CNT_EN.
- With the macro defined:
  - Adds output exc_cnt_o, 32 bits.
  - Increments by 1 on every exc_commit_o cycle and wraps from 32'hFFFF_FFFF to 0.
  - Unaffected by eret; cleared by rst_n.
- Without the macro: the port and counter are absent, and all other behaviour is identical.

Test Plan:
- status=32'h3, syscall_i=1, pc_i=32'h0040_0120 in cycle N -> stall_o=1 in N; N+1 exc_commit_o=1, cause_o=8, epc_o=32'h0040_0120; N+2 redirect_o=1, redirect_addr_o=32'h0040_0004; busy_o=0 at N+3.
- status=32'h1 (syscall masked), syscall_i=1 -> no stall, no strobe, no redirect, busy_o stays 0.
- status=32'h9, teq_i=1 with teq_eq_i=0 -> no action; repeat with teq_eq_i=1 -> cause_o=13 entry sequence.
- status=32'h7, break_i=1 and syscall_i=1 together -> cause_o=9 only; one exc_commit_o pulse.
- IDLE, eret_i=1, epc_i=32'h0040_0200 -> N+1 eret_commit_o=1; N+2 redirect_addr_o=32'h0040_0200.
- rst_n low during EXC_SAVE -> outputs 0 immediately, no redirect afterward; with EXC_CNT_EN, exc_cnt_o=0.
